// File: rtl/instr_fetch_unit.sv
// Instruction fetch: holds the fetch PC, reads instruction memory and queues words for the core.
// Latency: first request one cycle after reset release; a word is valid at the core one cycle after its ack.
// Backpressure: stops requesting while the prefetch queue has no room; redirect flushes the queue.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   mem_req/mem_addr/mem_ack/mem_rdata  instruction memory read handshake (request never withdrawn)
//   redirect/redirect_pc            flush and restart fetch at a new word-aligned target
//   inst_valid/inst_ready           head-of-queue handshake towards the core
//   inst_Din/inst_pc + fields       head instruction word, its address, and pre-split fields
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst_Din,
    output logic [31:0] inst_pc,
    output logic [5:0]  op_code,
    output logic [3:0]  inst_rd,
    output logic [3:0]  inst_rs1,
    output logic [3:0]  inst_rs2,
    output logic [13:0] inst_imm
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    // Address of the request left in flight when a redirect arrived before its ack.
    logic [31:0]   disc_addr_q, disc_addr_d;

    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pcs_q  [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic          push, pop, flush, space;
    logic [CW-1:0] count_net;
    logic [31:0]   target_pc;

    assign target_pc  = redirect_pc & ~32'h3;
    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid & inst_ready & ~redirect;
    // Occupancy once this cycle's pop is taken out; pop implies count_q > 0.
    assign count_net  = count_q - CW'(pop);
    assign space      = (count_net < CW'(DEPTH));

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        disc_addr_d = disc_addr_q;
        push        = 1'b0;
        flush       = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = fetch_pc_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = target_pc;
                    flush      = 1'b1;
                end else if (space) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (redirect) begin
                    fetch_pc_d = target_pc;
                    flush      = 1'b1;
                    if (mem_ack) begin
                        state_d = IDLE;
                    end else begin
                        // The in-flight read must still complete; remember where it went.
                        state_d     = DISCARD;
                        disc_addr_d = fetch_pc_q;
                    end
                end else if (mem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    // Room left after this push means another request can issue immediately.
                    state_d    = (count_net < CW'(DEPTH - 1)) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                mem_req  = 1'b1;
                mem_addr = disc_addr_q;
                if (redirect) begin
                    fetch_pc_d = target_pc;
                    flush      = 1'b1;
                end
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            disc_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            disc_addr_q <= disc_addr_d;
        end
    end

    // Prefetch queue: flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pcs_q[i]  <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= mem_rdata;
                pcs_q[wr_ptr_q]  <= fetch_pc_q;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign inst_Din = data_q[rd_ptr_q];
    assign inst_pc  = pcs_q[rd_ptr_q];
    assign op_code  = inst_Din[31:26];
    assign inst_rd  = inst_Din[25:22];
    assign inst_rs1 = inst_Din[21:18];
    assign inst_rs2 = inst_Din[17:14];
    assign inst_imm = inst_Din[13:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run checked against a stream model.
// Latency: memory responder answers after a programmable number of wait cycles.
// Backpressure: inst_ready driven per scenario, random in the randomized run.
module tb_instr_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst_Din, inst_pc;
    logic [5:0]  op_code;
    logic [3:0]  inst_rd, inst_rs1, inst_rs2;
    logic [13:0] inst_imm;

    int checks = 0;
    int errors = 0;

    // Memory responder controls
    int lat = 0;
    bit lat_rand = 0;
    bit mem_en = 1;

    instr_fetch_unit #(.RESET_PC(RPC), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_ready(inst_ready), .inst_valid(inst_valid),
        .inst_Din(inst_Din), .inst_pc(inst_pc), .op_code(op_code),
        .inst_rd(inst_rd), .inst_rs1(inst_rs1), .inst_rs2(inst_rs2), .inst_imm(inst_imm)
    );

    always #5 clk = ~clk;

    // Memory contents: address 0 holds 32'h0296_7D90, every other word is distinct.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return 32'h0296_7D90 ^ (a * 32'h9E37_79B1);
    endfunction

    // Responder: acks after cur_lat wait cycles, counted from the first cycle mem_req is seen.
    initial begin
        int wcnt;
        int cur_lat;
        wcnt = 0;
        cur_lat = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) wcnt = 0;
            if (mem_req && mem_en) begin
                if (wcnt == 0) cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat;
                mem_ack   = (wcnt >= cur_lat);
                mem_rdata = mem_ack ? memfn(mem_addr) : 32'hDEAD_BEEF;
                wcnt++;
            end else begin
                mem_ack = 1'b0;
                if (!mem_req) wcnt = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset(input int l);
        @(negedge clk);
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        lat = l; lat_rand = 1'b0; mem_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0; redirect = 1'b0; inst_ready = 1'b0; lat = 0; mem_en = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", inst_valid); end
        checks++; if (inst_Din !== 32'h0) begin errors++; $display("FAIL reset_din got %h want 0", inst_Din); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", inst_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL release_req got %b want 0", mem_req); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== RPC) begin
            errors++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, RPC);
        end
    endtask

    task automatic test_basic;
        apply_reset(0);
        inst_ready = 1'b1;
        @(negedge clk);
        checks++; if (mem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL basic_c1 got addr=%h valid=%b want addr=0 valid=0", mem_addr, inst_valid);
        end
        @(negedge clk);
        checks++; if (mem_addr !== 32'h4) begin errors++; $display("FAIL basic_addr4 got %h want 4", mem_addr); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_Din !== 32'h0296_7D90) begin
            errors++; $display("FAIL basic_head got v=%b pc=%h d=%h want v=1 pc=0 d=02967d90", inst_valid, inst_pc, inst_Din);
        end
        // 0x02967D90 split: [31:26]=0, [25:22]=A, [21:18]=5, [17:14]=9, [13:0]=3D90
        checks++; if (op_code !== 6'h0 || inst_rd !== 4'hA || inst_rs1 !== 4'h5 || inst_rs2 !== 4'h9 || inst_imm !== 14'h3D90) begin
            errors++; $display("FAIL basic_fields got op=%h rd=%h rs1=%h rs2=%h imm=%h want 0 a 5 9 3d90",
                               op_code, inst_rd, inst_rs1, inst_rs2, inst_imm);
        end
        @(negedge clk);
        checks++; if (mem_addr !== 32'h8) begin errors++; $display("FAIL basic_addr8 got %h want 8", mem_addr); end
    endtask

    task automatic test_back_to_back;
        apply_reset(0);
        inst_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k) || inst_Din !== memfn(32'(4 * k))) begin
                errors++; $display("FAIL b2b_%0d got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                                   k, inst_valid, inst_pc, inst_Din, 32'(4 * k), memfn(32'(4 * k)));
            end
        end
    endtask

    task automatic test_full;
        apply_reset(0);
        repeat (3) @(negedge clk);
        checks++; if (mem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            errors++; $display("FAIL full_hold got req=%b v=%b pc=%h want req=0 v=1 pc=0", mem_req, inst_valid, inst_pc);
        end
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_idle got req=%b want 0", mem_req); end
        inst_ready = 1'b1;
        @(negedge clk);
        checks++; if (inst_pc !== 32'h4 || mem_req !== 1'b1 || mem_addr !== 32'h8) begin
            errors++; $display("FAIL full_resume got pc=%h req=%b addr=%h want pc=4 req=1 addr=8", inst_pc, mem_req, mem_addr);
        end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8) begin
            errors++; $display("FAIL full_next got v=%b pc=%h want v=1 pc=8", inst_valid, inst_pc);
        end
    endtask

    task automatic test_discard;
        bit seen;
        apply_reset(3);
        @(negedge clk);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_0101;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL disc_hold got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr);
        end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || mem_ack !== 1'b1) begin
            errors++; $display("FAIL disc_ack got req=%b addr=%h ack=%b want 1 0 1", mem_req, mem_addr, mem_ack);
        end
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL disc_drop got req=%b v=%b want req=0 v=0", mem_req, inst_valid);
        end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            errors++; $display("FAIL disc_restart got req=%b addr=%h want req=1 addr=100", mem_req, mem_addr);
        end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (inst_valid === 1'b1) seen = 1;
        end
        checks++; if (!seen || inst_pc !== 32'h100 || inst_Din !== memfn(32'h100)) begin
            errors++; $display("FAIL disc_first got seen=%0d pc=%h d=%h want pc=100 d=%h", seen, inst_pc, inst_Din, memfn(32'h100));
        end
    endtask

    task automatic test_redirect_ack;
        apply_reset(0);
        @(negedge clk);
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || mem_ack !== 1'b1) begin
            errors++; $display("FAIL rack_setup got v=%b ack=%b want 1 1", inst_valid, mem_ack);
        end
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL rack_flush got v=%b req=%b want 0 0", inst_valid, mem_req);
        end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
            errors++; $display("FAIL rack_target got req=%b addr=%h want req=1 addr=200", mem_req, mem_addr);
        end
    endtask

    task automatic test_reset_in_discard;
        apply_reset(0);
        mem_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL rdisc_in got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL rdisc_async got req=%b v=%b want 0 0", mem_req, inst_valid);
        end
        @(negedge clk);
        rst_n = 1'b1; mem_en = 1'b1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== RPC) begin
            errors++; $display("FAIL rdisc_restart got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, RPC);
        end
    endtask

    // Stream model: consumed words form a run of consecutive addresses starting at the reset PC
    // or the latest redirect target, each carrying that address's memory word.
    task automatic test_random;
        logic [31:0] exp_pc, w, tgt, prev_addr;
        bit          prev_req, prev_ack, rdy, rdir;
        int          consumed;
        apply_reset(0);
        lat_rand = 1'b1;
        exp_pc = RPC; prev_req = 0; prev_ack = 0; prev_addr = '0; consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (prev_req && !prev_ack) begin
                checks++; if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
                    errors++; $display("FAIL rnd_stable c=%0d got req=%b addr=%h want req=1 addr=%h", c, mem_req, mem_addr, prev_addr);
                end
            end
            prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
            rdy  = ($urandom_range(0, 3) != 0);
            rdir = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 2))
                0: tgt = 32'hFFFF_FFF4 | 32'($urandom_range(0, 3));
                default: tgt = $urandom;
            endcase
            if (inst_valid === 1'b1 && rdy && !rdir) begin
                w = memfn(exp_pc);
                checks++; if (inst_pc !== exp_pc || inst_Din !== w || op_code !== w[31:26] || inst_rd !== w[25:22]
                              || inst_rs1 !== w[21:18] || inst_rs2 !== w[17:14] || inst_imm !== w[13:0]) begin
                    errors++; $display("FAIL rnd_consume c=%0d got pc=%h d=%h want pc=%h d=%h", c, inst_pc, inst_Din, exp_pc, w);
                end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (rdir) exp_pc = tgt & ~32'h3;
            inst_ready = rdy; redirect = rdir; redirect_pc = tgt;
        end
        @(negedge clk);
        redirect = 1'b0; inst_ready = 1'b0;
        checks++; if (consumed < 300) begin
            errors++; $display("FAIL rnd_progress got %0d consumed want at least 300", consumed);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_full();
        test_discard();
        test_redirect_ack();
        test_reset_in_discard();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
